alu_mul_seq: RTL and testbench



---
 rtl/alu_mul_pkg.sv | 22 ++
 rtl/alu_mul_seq_if.sv | 25 ++
 rtl/alu_mul_seq_yalu.sv | 26 ++
 rtl/alu_mul_seq.sv | 106 ++++++++++
 tb/tb_alu_mul_seq.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/alu_mul_pkg.sv
// Shared types and constants for the shift-add multiplier controller and its ALU.
package alu_mul_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned PROD_W   = 2 * DATA_W;
    localparam int unsigned MUL_ITER = 16;
    localparam int unsigned CNT_W    = $clog2(MUL_ITER);
    localparam int unsigned SH_W     = $clog2(MUL_ITER + 1);

    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_OR  = 3'b001;
    localparam logic [2:0] ALU_OP_ADD = 3'b010;
    localparam logic [2:0] ALU_OP_SUB = 3'b110;
    localparam logic [2:0] ALU_OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Operand/result handshake bundle between the multiplier controller and its user.
interface alu_mul_seq_if;
    import alu_mul_pkg::*;

    logic              start_valid;
    logic              start_ready;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic              busy;
    logic              done_valid;
    logic              done_ready;
    logic [PROD_W-1:0] product;
    logic              hi_nz;

    modport master (
        output start_valid, mcand, mplier, done_ready,
        input  start_ready, busy, done_valid, product, hi_nz
    );

    modport slave (
        input  start_valid, mcand, mplier, done_ready,
        output start_ready, busy, done_valid, product, hi_nz
    );

endinterface

// File: rtl/alu_mul_seq_yalu.sv
// Existing 16-bit datapath ALU (and/or/add/sub/slt) with zero flag.
module yAlu
    import alu_mul_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] z,
    output logic              zero
);

    always_comb begin
        z = '0;
        case (op)
            ALU_OP_AND: z = a & b;
            ALU_OP_OR:  z = a | b;
            ALU_OP_ADD: z = a + b;
            ALU_OP_SUB: z = a - b;
            ALU_OP_SLT: z = DATA_W'($signed(a) < $signed(b));
            default:    z = '0;
        endcase
    end

    assign zero = (z == '0);

endmodule

// File: rtl/alu_mul_seq.sv
// 16x16 unsigned shift-add multiplier sequencing yAlu, one add per cycle.
// Optional macro ALU_MUL_EARLY_EXIT_EN: finish early once the remaining multiplier bits are zero.
module alu_mul_seq
    import alu_mul_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic          clk,
    input  logic          resetn,
    alu_mul_seq_if.slave  bus
);

    state_t               state;
    logic [WIDTH-1:0]     mc;
    logic [WIDTH-1:0]     hi;
    logic [WIDTH-1:0]     lo;
    logic [CNT_W-1:0]     count;

    logic [WIDTH-1:0]     sum;
    logic [2:0]           alu_op;
    logic                 alu_zero_unused;
    logic                 carry;
    logic                 last;
    logic [2*WIDTH-1:0]   step_hilo;
    logic [2*WIDTH-1:0]   next_hilo;

`ifdef ALU_MUL_EARLY_EXIT_EN
    logic [WIDTH-1:0]     remain_mask;
    logic [SH_W-1:0]      shamt;
    logic                 early;
`endif

    assign alu_op = ALU_OP_ADD;

    yAlu u_alu (
        .a    (hi),
        .b    (mc),
        .op   (alu_op),
        .z    (sum),
        .zero (alu_zero_unused)
    );

    // Iteration datapath: ALU sum is 16 bits, so the carry out is rebuilt from the operand/sum MSBs.
    always_comb begin
        carry     = (hi[WIDTH-1] & mc[WIDTH-1]) | ((hi[WIDTH-1] | mc[WIDTH-1]) & ~sum[WIDTH-1]);
        step_hilo = lo[0] ? {carry, sum, lo[WIDTH-1:1]} : {1'b0, hi, lo[WIDTH-1:1]};
        next_hilo = step_hilo;
        last      = (count == CNT_W'(MUL_ITER - 1));
`ifdef ALU_MUL_EARLY_EXIT_EN
        // Low (16 - count) bits of lo are the multiplier bits not yet consumed.
        remain_mask = {WIDTH{1'b1}} >> count;
        early       = ((lo & remain_mask) == '0);
        shamt       = SH_W'(MUL_ITER) - SH_W'(count);
        if (early) begin
            next_hilo = {hi, lo} >> shamt;
            last      = 1'b1;
        end
`endif
    end

    // Controller state, working registers and registered result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            mc          <= '0;
            hi          <= '0;
            lo          <= '0;
            count       <= '0;
            bus.product <= '0;
            bus.hi_nz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        mc    <= bus.mcand;
                        hi    <= '0;
                        lo    <= bus.mplier;
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    {hi, lo} <= next_hilo;
                    count    <= count + CNT_W'(1);
                    if (last) begin
                        count       <= '0;
                        bus.product <= next_hilo;
                        bus.hi_nz   <= (next_hilo[2*WIDTH-1:WIDTH] != '0);
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.done_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.start_ready = (state == IDLE);
    assign bus.busy        = (state == RUN);
    assign bus.done_valid  = (state == DONE);

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq: vector table plus stall, ignored-start and mid-run reset sequences.
module tb_alu_mul_seq;

    logic clk = 1'b0;
    logic resetn;
    int   errors = 0;
    int   checks = 0;
    int   lat;

    typedef struct {
        logic [15:0] mc;
        logic [15:0] mp;
        logic [31:0] prod;
        logic        hnz;
    } vec_t;

    vec_t vecs[10];

    alu_mul_seq_if bus();

    alu_mul_seq #(.WIDTH(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [15:0] mp);
`ifdef ALU_MUL_EARLY_EXIT_EN
        int m;
        if (mp == 16'h0000) return 1;
        m = 0;
        for (int i = 0; i < 16; i++) if (mp[i]) m = i;
        return (m + 2 > 16) ? 16 : m + 2;
`else
        return 16;
`endif
    endfunction

    // Accept one operation and count clock edges until done_valid is seen (bounded).
    task automatic run_op(input logic [15:0] mc, input logic [15:0] mp, input bit interfere,
                          output int cycles);
        @(negedge clk);
        check("start_ready_idle", 32'(bus.start_ready), 32'd1);
        bus.start_valid = 1'b1;
        bus.mcand       = mc;
        bus.mplier      = mp;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        bus.mcand       = ~mc;
        bus.mplier      = ~mp;
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        cycles = 0;
        while (cycles < 40) begin
            @(posedge clk);
            cycles++;
            #1;
            if (interfere) begin
                if (cycles == 1) begin
                    bus.start_valid = 1'b1;
                    bus.mcand       = 16'hFFFF;
                    bus.mplier      = 16'hFFFF;
                end else begin
                    bus.start_valid = 1'b0;
                end
            end
            if (bus.done_valid) break;
        end
    endtask

    initial begin
        vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F, 1'b0};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1};
        vecs[2] = '{16'h1234, 16'h0000, 32'h00000000, 1'b0};
        vecs[3] = '{16'h0007, 16'h0009, 32'h0000003F, 1'b0};
        vecs[4] = '{16'h8000, 16'h0002, 32'h00010000, 1'b1};
        vecs[5] = '{16'hFFFF, 16'h0001, 32'h0000FFFF, 1'b0};
        vecs[6] = '{16'h0001, 16'h8000, 32'h00008000, 1'b0};
        vecs[7] = '{16'h1234, 16'h5678, 32'h06260060, 1'b1};
        vecs[8] = '{16'hABCD, 16'h0010, 32'h000ABCD0, 1'b1};
        vecs[9] = '{16'h0100, 16'h0100, 32'h00010000, 1'b1};

        resetn          = 1'b0;
        bus.start_valid = 1'b0;
        bus.mcand       = '0;
        bus.mplier      = '0;
        bus.done_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_start_ready", 32'(bus.start_ready), 32'd1);
        check("rst_busy",        32'(bus.busy),        32'd0);
        check("rst_done_valid",  32'(bus.done_valid),  32'd0);
        check("rst_product",     bus.product,          32'h0);
        check("rst_hi_nz",       32'(bus.hi_nz),       32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Table vectors with the consumer always ready.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].mc, vecs[i].mp, 1'b0, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].mp)));
            check($sformatf("v%0d_product", i), bus.product, vecs[i].prod);
            check($sformatf("v%0d_hi_nz", i), 32'(bus.hi_nz), 32'(vecs[i].hnz));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_1cyc", i), 32'(bus.done_valid), 32'd0);
            check($sformatf("v%0d_back_idle", i), 32'(bus.start_ready), 32'd1);
            check($sformatf("v%0d_prod_hold", i), bus.product, vecs[i].prod);
        end

        // Consumer stalls in DONE; a start request there must be ignored.
        bus.done_ready = 1'b0;
        run_op(16'h0100, 16'h0100, 1'b0, lat);
        check("stall_latency", 32'(lat), 32'(exp_lat(16'h0100)));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_done_valid", k), 32'(bus.done_valid), 32'd1);
            check($sformatf("stall%0d_product", k), bus.product, 32'h00010000);
            check($sformatf("stall%0d_start_ready", k), 32'(bus.start_ready), 32'd0);
            if (k == 2) begin
                bus.start_valid = 1'b1;
                bus.mcand       = 16'h0002;
                bus.mplier      = 16'h0002;
            end else begin
                bus.start_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.done_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release_done", 32'(bus.done_valid), 32'd0);
        check("stall_release_idle", 32'(bus.start_ready), 32'd1);
        check("stall_release_prod", bus.product, 32'h00010000);
        check("stall_release_busy", 32'(bus.busy), 32'd0);

        // New operands offered while running must not disturb the result.
        run_op(16'h0003, 16'h0005, 1'b1, lat);
        check("ign_latency", 32'(lat), 32'(exp_lat(16'h0005)));
        check("ign_product", bus.product, 32'h0000000F);
        check("ign_hi_nz", 32'(bus.hi_nz), 32'd0);
        @(posedge clk);
        #1;
        check("ign_back_idle", 32'(bus.start_ready), 32'd1);
        check("ign_no_restart", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of a long multiply.
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.mcand       = 16'hFFFF;
        bus.mplier      = 16'hFFFF;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("midrst_busy_before", 32'(bus.busy), 32'd1);
        resetn = 1'b0;
        #1;
        check("midrst_start_ready", 32'(bus.start_ready), 32'd1);
        check("midrst_busy",        32'(bus.busy),        32'd0);
        check("midrst_done_valid",  32'(bus.done_valid),  32'd0);
        check("midrst_product",     bus.product,          32'h0);
        check("midrst_hi_nz",       32'(bus.hi_nz),       32'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_op(16'h0007, 16'h0009, 1'b0, lat);
        check("post_rst_latency", 32'(lat), 32'(exp_lat(16'h0009)));
        check("post_rst_product", bus.product, 32'h0000003F);
        check("post_rst_hi_nz", 32'(bus.hi_nz), 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_idle", 32'(bus.start_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
